// File: rtl/display_scan_counter.sv
// Digit-scan index generator: a prescaler divides the system clock into digit
// slots, and each slot boundary advances the index to the next unmasked digit.
module display_scan_counter #(
  parameter int DIV = 50000,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic [3:0] Mask,
  output logic [1:0] Out,
  output logic       Tick,
  output logic       FrameDone,
  output logic       Blank
);

  localparam logic [CW-1:0] P_LAST = CW'(DIV - 1);

  logic [CW-1:0] p_reg, p_next;
  logic [1:0]    out_reg, out_next;
  logic          tick_reg, tick_next;
  logic          frame_reg, frame_next;

  logic [1:0]    cand [4];
  logic [3:0]    hit;
  logic [1:0]    scan_idx;
  logic          advance;

  // Candidate gi is Out+gi+1; the last candidate wraps back onto Out itself.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand[gi] = out_reg + 2'(gi + 1);
    assign hit[gi]  = Mask[cand[gi]];
  end

  always_comb begin
    scan_idx = out_reg;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) scan_idx = cand[k];
    end
  end

  assign advance = Enable && (p_reg == P_LAST);

  always_comb begin
    p_next     = p_reg;
    out_next   = out_reg;
    tick_next  = 1'b0;
    frame_next = 1'b0;
    if (advance) begin
      p_next = '0;
      if (|Mask) begin
        out_next   = scan_idx;
        tick_next  = 1'b1;
        frame_next = (scan_idx <= out_reg);
      end
    end else if (Enable) begin
      p_next = p_reg + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      p_reg     <= '0;
      out_reg   <= 2'd0;
      tick_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      p_reg     <= p_next;
      out_reg   <= out_next;
      tick_reg  <= tick_next;
      frame_reg <= frame_next;
    end
  end

  assign Out       = out_reg;
  assign Tick      = tick_reg;
  assign FrameDone = frame_reg;
  assign Blank     = ~|Mask;

endmodule

// File: tb/tb_display_scan_counter.sv
// Directed bench for display_scan_counter with DIV=4.
module tb_display_scan_counter;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Enable;
  logic [3:0] Mask;
  logic [1:0] Out;
  logic       Tick;
  logic       FrameDone;
  logic       Blank;

  int pass_cnt = 0;
  int check_cnt = 0;

  display_scan_counter #(.DIV(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Mask(Mask),
    .Out(Out), .Tick(Tick), .FrameDone(FrameDone), .Blank(Blank)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int obs, input int exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic edge_step();
    @(posedge Clock);
    #1;
  endtask

  // Counts edges until Tick appears (bounded), then checks slot length and outputs.
  task automatic wait_tick(input string tag, input int exp_len,
                           input int exp_out, input int exp_fd);
    int cnt = 0;
    while (cnt < 40) begin
      edge_step();
      cnt++;
      if (Tick === 1'b1) break;
    end
    check({tag, "_len"}, cnt, exp_len);
    check({tag, "_out"}, int'(Out), exp_out);
    check({tag, "_fd"}, int'(FrameDone), exp_fd);
    $display("slot %s: len=%0d out=%0d tick=%0d fd=%0d", tag, cnt, Out, Tick, FrameDone);
  endtask

  initial begin
    Reset_n = 1'b0;
    Enable  = 1'b1;
    Mask    = 4'b1111;
    #12;
    check("rst_out", int'(Out), 0);
    check("rst_tick", int'(Tick), 0);
    check("rst_fd", int'(FrameDone), 0);
    check("rst_blank", int'(Blank), 0);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    // Full scan
    wait_tick("full1", 4, 1, 0);
    wait_tick("full2", 4, 2, 0);
    wait_tick("full3", 4, 3, 0);
    wait_tick("full0", 4, 0, 1);

    // Skip masked digits
    Mask = 4'b1010;
    wait_tick("skip1", 4, 1, 0);
    wait_tick("skip3", 4, 3, 0);
    wait_tick("skip1b", 4, 1, 1);
    wait_tick("skip3b", 4, 3, 0);

    // Single digit: 3 wraps to 2, then 2 reselects itself every slot
    Mask = 4'b0100;
    wait_tick("single_a", 4, 2, 1);
    wait_tick("single_b", 4, 2, 1);
    wait_tick("single_c", 4, 2, 1);

    // All masked
    Mask = 4'b0000;
    #1;
    check("blank_on", int'(Blank), 1);
    for (int i = 0; i < 12; i++) begin
      edge_step();
      check("masked_tick", int'(Tick), 0);
      check("masked_out", int'(Out), 2);
    end
    $display("masked: 12 edges out=%0d tick=%0d", Out, Tick);
    Mask = 4'b0001;
    #1;
    check("blank_off", int'(Blank), 0);
    wait_tick("unmask", 4, 0, 1);

    // Enable gating at P=2
    Mask = 4'b1111;
    edge_step();
    edge_step();
    Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_step();
      check("dis_tick", int'(Tick), 0);
      check("dis_out", int'(Out), 0);
    end
    Enable = 1'b1;
    wait_tick("gate_tail", 2, 1, 0);
    wait_tick("gate_norm", 4, 2, 0);

    // Reset mid-slot at Out=2, P=3
    edge_step();
    edge_step();
    edge_step();
    check("pre_rst_out", int'(Out), 2);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_out", int'(Out), 0);
    check("mid_rst_tick", int'(Tick), 0);
    check("mid_rst_fd", int'(FrameDone), 0);
    #1;
    Reset_n = 1'b1;
    wait_tick("post_rst", 4, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
